// File: rtl/dmem_pkg.sv
// dmem_pkg: constants, types and helpers shared by the data-memory responder
// and the MIPS datapath.
//   - word/byte-lane widths for the load/store path
//   - error code constants carried on resp_err
//   - responder FSM state encoding
//   - addr_error(): misalignment / out-of-range check for a request address
package dmem_pkg;

  localparam int unsigned WORD_BITS = 32;
  localparam int unsigned BYTE_BITS = 8;
  localparam int unsigned LANES     = WORD_BITS / BYTE_BITS;

  localparam logic DMEM_ERR_NONE = 1'b0;
  localparam logic DMEM_ERR_ADDR = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // A word access is legal only when it is 4-byte aligned and every address
  // bit above the storage range is zero.
  function automatic logic addr_error(input logic [31:0] addr,
                                      input int unsigned abits);
    logic misaligned;
    logic out_of_range;
    misaligned   = (addr[1:0] != 2'b00);
    out_of_range = ((addr >> abits) != 32'h0000_0000);
    return (misaligned || out_of_range) ? DMEM_ERR_ADDR : DMEM_ERR_NONE;
  endfunction

endpackage

// File: rtl/dmem_storage.sv
// dmem_storage: byte-organised data storage, 2**ADDR_BITS bytes.
// Ports:
//   clk    in   clock; writes happen on posedge
//   word   in   word index (byte address bits [ADDR_BITS-1:2])
//   we     in   per-byte-lane write enable, lane i -> byte address word*4+i
//   wdata  in   store data, lane i = wdata[8i+7:8i]
//   rdata  out  combinational little-endian word read of the same word
// Contents are never reset.
module dmem_storage
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic                   clk,
  input  logic [ADDR_BITS-3:0]   word,
  input  logic [LANES-1:0]       we,
  input  logic [WORD_BITS-1:0]   wdata,
  output logic [WORD_BITS-1:0]   rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;

  logic [BYTE_BITS-1:0] mem [0:DEPTH-1];

  // Byte-lane write; an aligned word index keeps all four lanes inside the array.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(LANES); i++) begin
      if (we[i]) begin
        mem[{word, 2'(i)}] <= wdata[BYTE_BITS*i +: BYTE_BITS];
      end
    end
  end

  // Little-endian assembly: lowest byte address lands in bits [7:0].
  always_comb begin
    rdata = {WORD_BITS{1'b0}};
    for (int i = 0; i < int'(LANES); i++) begin
      rdata[BYTE_BITS*i +: BYTE_BITS] = mem[{word, 2'(i)}];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: clocked, stallable data-memory target for lw/sw.
// Accepts one word request on a valid/ready handshake, spends WAIT_CYCLES in
// WAIT, commits the access on entry to RESP and holds the response until
// resp_ready.
// Ports:
//   CLK, RESET             clock, synchronous active-high reset
//   req_valid/req_ready    request handshake (ready only in IDLE)
//   req_write              1 = store word, 0 = load word
//   req_addr, req_wdata    byte address and store data
//   resp_valid/resp_ready  response handshake
//   resp_rdata             load data (0 for stores and errors)
//   resp_err               misaligned or out-of-range address
//   busy                   FSM not in IDLE
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_BITS   = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [WORD_BITS-1:0]  req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [WORD_BITS-1:0]  resp_rdata,
  output logic                  resp_err,
  output logic                  busy
);

  localparam int unsigned CNT_W     = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : {CNT_W{1'b0}};
  localparam logic ZERO_WAIT = (WAIT_CYCLES == 0) ? 1'b1 : 1'b0;

  dmem_state_t           state;
  logic [CNT_W-1:0]      cnt;
  logic                  cap_write;
  logic [ADDR_BITS-3:0]  cap_word;
  logic [WORD_BITS-1:0]  cap_wdata;
  logic                  cap_err;

  logic                  accept;
  logic                  req_err;
  logic                  commit;
  logic                  src_write;
  logic [ADDR_BITS-3:0]  src_word;
  logic [WORD_BITS-1:0]  src_wdata;
  logic                  src_err;
  logic [LANES-1:0]      we;
  logic [WORD_BITS-1:0]  store_rdata;

  assign accept  = (state == IDLE) && req_valid && req_ready;
  assign req_err = addr_error(req_addr, ADDR_BITS);

  // The commit uses the live request when WAIT_CYCLES=0 (commit on the accept
  // edge), otherwise the fields captured at accept.
  always_comb begin
    src_write = cap_write;
    src_word  = cap_word;
    src_wdata = cap_wdata;
    src_err   = cap_err;
    if (state == IDLE) begin
      src_write = req_write;
      src_word  = req_addr[ADDR_BITS-1:2];
      src_wdata = req_wdata;
      src_err   = req_err;
    end else begin
      src_write = cap_write;
    end
    case (state)
      IDLE:    commit = accept && ZERO_WAIT;
      WAIT:    commit = (cnt == CNT_LAST);
      RESP:    commit = 1'b0;
      default: commit = 1'b0;
    endcase
    if (commit && src_write && (src_err == DMEM_ERR_NONE)) begin
      we = {LANES{1'b1}};
    end else begin
      we = {LANES{1'b0}};
    end
  end

  dmem_storage #(
    .ADDR_BITS (ADDR_BITS)
  ) u_storage (
    .clk   (CLK),
    .word  (src_word),
    .we    (we),
    .wdata (src_wdata),
    .rdata (store_rdata)
  );

  // Responder FSM with registered handshake and response outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      cnt        <= {CNT_W{1'b0}};
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= {WORD_BITS{1'b0}};
      resp_err   <= DMEM_ERR_NONE;
      busy       <= 1'b0;
      cap_write  <= 1'b0;
      cap_word   <= {(ADDR_BITS-2){1'b0}};
      cap_wdata  <= {WORD_BITS{1'b0}};
      cap_err    <= DMEM_ERR_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cap_write <= req_write;
            cap_word  <= req_addr[ADDR_BITS-1:2];
            cap_wdata <= req_wdata;
            cap_err   <= req_err;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            cnt       <= {CNT_W{1'b0}};
            if (ZERO_WAIT) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= req_err;
              resp_rdata <= (req_write || req_err) ? {WORD_BITS{1'b0}} : store_rdata;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == CNT_LAST) begin
            state      <= RESP;
            cnt        <= {CNT_W{1'b0}};
            resp_valid <= 1'b1;
            resp_err   <= cap_err;
            resp_rdata <= (cap_write || cap_err) ? {WORD_BITS{1'b0}} : store_rdata;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          // Response fields stay frozen until the datapath takes them.
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= {WORD_BITS{1'b0}};
            resp_err   <= DMEM_ERR_NONE;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          cnt        <= {CNT_W{1'b0}};
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_rdata <= {WORD_BITS{1'b0}};
          resp_err   <= DMEM_ERR_NONE;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder.
// dut_a runs with WAIT_CYCLES=2, dut_b with WAIT_CYCLES=0; both ADDR_BITS=10.
module tb_dmem_responder;

  logic        clk;
  logic        rst;

  logic        a_req_valid, a_req_ready, a_req_write;
  logic [31:0] a_req_addr, a_req_wdata;
  logic        a_resp_valid, a_resp_ready, a_resp_err, a_busy;
  logic [31:0] a_resp_rdata;

  logic        b_req_valid, b_req_ready, b_req_write;
  logic [31:0] b_req_addr, b_req_wdata;
  logic        b_resp_valid, b_resp_ready, b_resp_err, b_busy;
  logic [31:0] b_resp_rdata;

  int checks;
  int failures;

  dmem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(2)) dut_a (
    .CLK(clk), .RESET(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err), .busy(a_busy)
  );

  dmem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(0)) dut_b (
    .CLK(clk), .RESET(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request to dut_a, count edges from the accept edge until
  // resp_valid (lat=-1 on timeout); the response is left pending.
  task automatic issue_a(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd, output logic er);
    @(negedge clk);
    a_req_valid = 1'b1; a_req_write = wr; a_req_addr = addr; a_req_wdata = wd;
    a_resp_ready = 1'b0;
    @(posedge clk); #1;
    a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = 32'h0; a_req_wdata = 32'h0;
    lat = 1;
    while (a_resp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (a_resp_valid !== 1'b1) lat = -1;
    rd = a_resp_rdata;
    er = a_resp_err;
  endtask

  task automatic release_a();
    @(negedge clk);
    a_resp_ready = 1'b1;
    @(posedge clk); #1;
    a_resp_ready = 1'b0;
  endtask

  task automatic issue_b(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd, output logic er);
    @(negedge clk);
    b_req_valid = 1'b1; b_req_write = wr; b_req_addr = addr; b_req_wdata = wd;
    b_resp_ready = 1'b0;
    @(posedge clk); #1;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = 32'h0; b_req_wdata = 32'h0;
    lat = 1;
    while (b_resp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (b_resp_valid !== 1'b1) lat = -1;
    rd = b_resp_rdata;
    er = b_resp_err;
  endtask

  task automatic release_b();
    @(negedge clk);
    b_resp_ready = 1'b1;
    @(posedge clk); #1;
    b_resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (a_req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got %b want 1", a_req_ready); end
    checks++; if (a_resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got %b want 0", a_resp_valid); end
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", a_busy); end
    checks++; if (a_resp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got %h want 0", a_resp_rdata); end
    checks++; if (a_resp_err !== 1'b0) begin failures++; $display("FAIL reset_err got %b want 0", a_resp_err); end
    checks++; if (b_req_ready !== 1'b1) begin failures++; $display("FAIL reset_b_req_ready got %b want 1", b_req_ready); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rd; logic er;
    issue_a(1'b1, 32'h0000_000C, 32'hDEAD_BEEF, lat, rd, er);
    checks++; if (lat !== 3) begin failures++; $display("FAIL wr_latency got %0d want 3", lat); end
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL wr_rdata got %h want 0", rd); end
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL wr_err got %b want 0", er); end
    release_a();
    issue_a(1'b0, 32'h0000_000C, 32'h0, lat, rd, er);
    checks++; if (lat !== 3) begin failures++; $display("FAIL rd_latency got %0d want 3", lat); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_data got %h want deadbeef", rd); end
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL rd_err got %b want 0", er); end
    release_a();
    checks++; if (dut_a.u_storage.mem[12] !== 8'hEF) begin failures++; $display("FAIL byte_0c got %h want ef", dut_a.u_storage.mem[12]); end
    checks++; if (dut_a.u_storage.mem[15] !== 8'hDE) begin failures++; $display("FAIL byte_0f got %h want de", dut_a.u_storage.mem[15]); end
    // Topmost word of the array.
    issue_a(1'b1, 32'h0000_03FC, 32'h0102_0304, lat, rd, er);
    release_a();
    issue_a(1'b0, 32'h0000_03FC, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h0102_0304) begin failures++; $display("FAIL top_word got %h want 01020304", rd); end
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL top_word_err got %b want 0", er); end
    release_a();
    checks++; if (dut_a.u_storage.mem[1023] !== 8'h01) begin failures++; $display("FAIL byte_3ff got %h want 01", dut_a.u_storage.mem[1023]); end
  endtask

  task automatic test_misaligned();
    int lat; logic [31:0] rd; logic er;
    issue_a(1'b1, 32'h0000_0008, 32'h55AA_33CC, lat, rd, er);
    release_a();
    issue_a(1'b1, 32'h0000_000A, 32'h1234_5678, lat, rd, er);
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL misal_err got %b want 1", er); end
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL misal_rdata got %h want 0", rd); end
    checks++; if (lat !== 3) begin failures++; $display("FAIL misal_latency got %0d want 3", lat); end
    release_a();
    issue_a(1'b0, 32'h0000_0008, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h55AA_33CC) begin failures++; $display("FAIL misal_prior got %h want 55aa33cc", rd); end
    release_a();
    issue_a(1'b0, 32'h0000_0009, 32'h0, lat, rd, er);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL misal_read got err=%b rd=%h want err=1 rd=0", er, rd); end
    release_a();
  endtask

  task automatic test_out_of_range();
    int lat; logic [31:0] rd; logic er;
    issue_a(1'b0, 32'h0000_0400, 32'h0, lat, rd, er);
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL oor_err got %b want 1", er); end
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL oor_rdata got %h want 0", rd); end
    checks++; if (lat !== 3) begin failures++; $display("FAIL oor_latency got %0d want 3", lat); end
    release_a();
    // An out-of-range store must not alias onto 0x0C.
    issue_a(1'b1, 32'h8000_040C, 32'h9999_9999, lat, rd, er);
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL oor_wr_err got %b want 1", er); end
    release_a();
    issue_a(1'b0, 32'h0000_000C, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL oor_alias got %h want deadbeef", rd); end
    release_a();
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] rd; logic er;
    issue_a(1'b0, 32'h0000_000C, 32'h0, lat, rd, er);
    @(negedge clk);
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 32'h0000_000C; a_req_wdata = 32'h7777_7777;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (a_resp_valid !== 1'b1 || a_resp_rdata !== 32'hDEAD_BEEF || a_req_ready !== 1'b0 || a_busy !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d got v=%b rd=%h rdy=%b busy=%b want v=1 rd=deadbeef rdy=0 busy=1",
                 i, a_resp_valid, a_resp_rdata, a_req_ready, a_busy);
      end
    end
    @(negedge clk);
    a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = 32'h0; a_req_wdata = 32'h0;
    a_resp_ready = 1'b1;
    @(posedge clk); #1;
    a_resp_ready = 1'b0;
    checks++; if (a_resp_valid !== 1'b0 || a_req_ready !== 1'b1 || a_busy !== 1'b0 || a_resp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL bp_release got v=%b rdy=%b busy=%b rd=%h want v=0 rdy=1 busy=0 rd=0",
               a_resp_valid, a_req_ready, a_busy, a_resp_rdata);
    end
    issue_a(1'b0, 32'h0000_000C, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL bp_ignored_write got %h want deadbeef", rd); end
    release_a();
  endtask

  task automatic test_reset_mid_wait();
    int lat; logic [31:0] rd; logic er;
    issue_a(1'b1, 32'h0000_0010, 32'h0BAD_C0DE, lat, rd, er);
    release_a();
    @(negedge clk);
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 32'h0000_0010; a_req_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    a_req_valid = 1'b0; a_req_write = 1'b0;
    checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL rmw_in_wait got busy=%b want 1", a_busy); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (a_busy !== 1'b0 || a_req_ready !== 1'b1 || a_resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL rmw_idle got busy=%b rdy=%b v=%b want 0 1 0", a_busy, a_req_ready, a_resp_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (a_resp_valid !== 1'b0) begin failures++; $display("FAIL rmw_no_resp got %b want 0", a_resp_valid); end
    issue_a(1'b0, 32'h0000_0010, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h0BAD_C0DE) begin failures++; $display("FAIL rmw_not_committed got %h want 0badc0de", rd); end
    release_a();
  endtask

  task automatic test_zero_wait();
    int lat; logic [31:0] rd; logic er;
    issue_b(1'b1, 32'h0000_000C, 32'hDEAD_BEEF, lat, rd, er);
    checks++; if (lat !== 1) begin failures++; $display("FAIL zw_wr_latency got %0d want 1", lat); end
    checks++; if (er !== 1'b0 || rd !== 32'h0) begin failures++; $display("FAIL zw_wr_resp got err=%b rd=%h want 0 0", er, rd); end
    release_b();
    issue_b(1'b0, 32'h0000_000C, 32'h0, lat, rd, er);
    checks++; if (lat !== 1) begin failures++; $display("FAIL zw_rd_latency got %0d want 1", lat); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL zw_rd_data got %h want deadbeef", rd); end
    release_b();
    issue_b(1'b0, 32'h0000_0402, 32'h0, lat, rd, er);
    checks++; if (er !== 1'b1 || lat !== 1) begin failures++; $display("FAIL zw_err got err=%b lat=%0d want 1 1", er, lat); end
    release_b();
    checks++; if (b_req_ready !== 1'b1 || b_busy !== 1'b0) begin failures++; $display("FAIL zw_idle got rdy=%b busy=%b want 1 0", b_req_ready, b_busy); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1;
    a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = 32'h0; a_req_wdata = 32'h0; a_resp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = 32'h0; b_req_wdata = 32'h0; b_resp_ready = 1'b0;
    test_reset();
    test_write_read();
    test_misaligned();
    test_out_of_range();
    test_backpressure();
    test_reset_mid_wait();
    test_zero_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
